// File: rtl/filtez.sv
// filtez: multiply-accumulate over TAPS coefficient/delay-line pairs read
// from two single-port RAMs (one-cycle read latency). The sum is arithmetic
// shifted right by SHIFT, and the low 32 bits are returned.
// Handshake: ap_start / ap_done / ap_idle / ap_ready.
module filtez #(
  parameter int TAPS  = 6,
  parameter int SHIFT = 14
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [2:0]  bli_address0,
  output logic        bli_ce0,
  input  logic [31:0] bli_q0,
  output logic [2:0]  dlti_address0,
  output logic        dlti_ce0,
  input  logic [31:0] dlti_q0,
  output logic [31:0] ap_return
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST = 3'(TAPS - 1);

  state_t             state_reg;
  logic [2:0]         i_reg;
  logic signed [63:0] acc_reg;
  logic [31:0]        ret_reg;
  logic               done_reg;

  logic signed [63:0] product;
  logic signed [63:0] sum_next;
  logic               fetch;
  logic [2:0]         addr_next;

  // Full-width signed product of the two RAM words that arrived this cycle
  assign product = $signed({{32{bli_q0[31]}}, bli_q0}) *
                   $signed({{32{dlti_q0[31]}}, dlti_q0});

  // Running sum including the current product; index 0 starts a fresh sum
  assign sum_next = (i_reg == 3'd0) ? product : acc_reg + product;

  // RAM read requests: first fetch issued on the start cycle, then one per
  // LOOP cycle until the last tap; address parked at 0 whenever ce is low.
  // ce is held low while reset is asserted.
  always_comb begin
    fetch     = 1'b0;
    addr_next = 3'd0;
    if (state_reg == IDLE && ap_start) begin
      fetch     = 1'b1;
      addr_next = 3'd0;
    end else if (state_reg == LOOP && i_reg != LAST) begin
      fetch     = 1'b1;
      addr_next = 3'(i_reg + 3'd1);
    end
    if (!ap_rst_n) begin
      fetch     = 1'b0;
      addr_next = 3'd0;
    end
  end

  assign bli_ce0       = fetch;
  assign dlti_ce0      = fetch;
  assign bli_address0  = addr_next;
  assign dlti_address0 = addr_next;

  assign ap_idle   = (state_reg == IDLE) && !ap_start;
  assign ap_done   = done_reg;
  assign ap_ready  = done_reg;
  assign ap_return = ret_reg;

  // Control FSM, accumulator and registered result/done pulse
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg <= IDLE;
      i_reg     <= 3'd0;
      acc_reg   <= 64'sd0;
      ret_reg   <= 32'd0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ap_start) begin
            i_reg     <= 3'd0;
            state_reg <= LOOP;
          end
        end
        LOOP: begin
          acc_reg <= sum_next;
          if (i_reg == LAST) begin
            ret_reg   <= 32'(sum_next >>> SHIFT);
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            i_reg <= 3'(i_reg + 3'd1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filtez.sv
// Testbench for filtez: RAM models with one-cycle read latency, directed
// cases, random contents checked against a plain-arithmetic reference,
// mid-run reset, and back-to-back runs with ap_start held high.
module tb_filtez;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [2:0]  bli_address0;
  logic        bli_ce0;
  logic [31:0] bli_q0;
  logic [2:0]  dlti_address0;
  logic        dlti_ce0;
  logic [31:0] dlti_q0;
  logic [31:0] ap_return;

  logic [31:0] bli_mem  [0:7];
  logic [31:0] dlti_mem [0:7];

  int checks = 0;
  int errors = 0;

  filtez #(.TAPS(6), .SHIFT(14)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .bli_address0 (bli_address0),
    .bli_ce0      (bli_ce0),
    .bli_q0       (bli_q0),
    .dlti_address0(dlti_address0),
    .dlti_ce0     (dlti_ce0),
    .dlti_q0      (dlti_q0),
    .ap_return    (ap_return)
  );

  always #5 ap_clk = ~ap_clk;

  // RAM models: registered read when ce is high
  always @(posedge ap_clk) begin
    if (bli_ce0)  bli_q0  <= bli_mem[bli_address0];
    if (dlti_ce0) dlti_q0 <= dlti_mem[dlti_address0];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed dot product of the six taps, floor-shifted by 14
  function automatic logic [31:0] ref_filter();
    longint acc = 0;
    for (int k = 0; k < 6; k++)
      acc += longint'($signed(bli_mem[k])) * longint'($signed(dlti_mem[k]));
    return 32'(acc >>> 14);
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 8; k++) begin
      bli_mem[k]  = 32'd0;
      dlti_mem[k] = 32'd0;
    end
  endtask

  task automatic random_mem();
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int k = 0; k < 6; k++) begin
      case (mode)
        0: begin
          bli_mem[k]  = 32'($signed($urandom_range(0, 2000)) - 1000);
          dlti_mem[k] = 32'($signed($urandom_range(0, 200000)) - 100000);
        end
        1: begin
          bli_mem[k]  = $urandom;
          dlti_mem[k] = $urandom;
        end
        default: begin
          bli_mem[k]  = (k % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          dlti_mem[k] = 32'h8000_0000 | 32'($urandom_range(0, 15));
        end
      endcase
    end
  endtask

  // One evaluation: start in cycle 0, check handshake, address trace and result
  task automatic run_eval(input string name, input logic [31:0] exp);
    for (int c = 0; c < 9; c++) begin
      @(posedge ap_clk); #1;
      ap_start = (c == 0);
      #4;
      check_eq($sformatf("%s_done_c%0d", name, c), ap_done, (c == 7));
      check_eq($sformatf("%s_ready_c%0d", name, c), ap_ready, (c == 7));
      check_eq($sformatf("%s_idle_c%0d", name, c), ap_idle, (c == 8));
      if (c <= 7) begin
        check_eq($sformatf("%s_bce_c%0d", name, c), bli_ce0, (c <= 5));
        check_eq($sformatf("%s_dce_c%0d", name, c), dlti_ce0, (c <= 5));
        check_eq($sformatf("%s_badr_c%0d", name, c), bli_address0, (c <= 5) ? c : 0);
        check_eq($sformatf("%s_dadr_c%0d", name, c), dlti_address0, (c <= 5) ? c : 0);
      end
      if (c >= 7) check_eq($sformatf("%s_ret_c%0d", name, c), ap_return, exp);
    end
    $display("run %s: ap_return=0x%08h expected=0x%08h", name, ap_return, exp);
  endtask

  initial begin
    logic [31:0] exp;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    bli_q0   = 32'd0;
    dlti_q0  = 32'd0;
    clear_mem();

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    check_eq("rst_done", ap_done, 0);
    check_eq("rst_ready", ap_ready, 0);
    check_eq("rst_ret", ap_return, 0);
    check_eq("rst_bce", bli_ce0, 0);
    check_eq("rst_dce", dlti_ce0, 0);
    check_eq("rst_badr", bli_address0, 0);
    check_eq("rst_idle", ap_idle, 1);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check_eq("post_rst_idle", ap_idle, 1);

    // Directed: unit coefficients
    for (int k = 0; k < 6; k++) begin bli_mem[k] = 32'd1; dlti_mem[k] = 32'd16384; end
    run_eval("ones", 32'd6);

    // Directed: rising coefficients, truncation toward -inf
    for (int k = 0; k < 6; k++) begin bli_mem[k] = 32'(k + 1); dlti_mem[k] = 32'd8192; end
    run_eval("ramp", 32'd10);

    // Directed: negative results
    clear_mem();
    bli_mem[0] = 32'hFFFF_FFFD; dlti_mem[0] = 32'd8192;
    run_eval("neg3", 32'hFFFF_FFFE);
    bli_mem[0] = 32'hFFFF_FFFF; dlti_mem[0] = 32'd1;
    run_eval("neg1", 32'hFFFF_FFFF);

    // Random contents against the reference
    for (int r = 0; r < 20; r++) begin
      random_mem();
      exp = ref_filter();
      run_eval($sformatf("rnd%0d", r), exp);
    end

    // Mid-run reset: make the previous result nonzero first
    for (int k = 0; k < 6; k++) begin bli_mem[k] = 32'd1; dlti_mem[k] = 32'd16384; end
    run_eval("pre_abort", 32'd6);
    for (int c = 0; c < 4; c++) begin
      @(posedge ap_clk); #1;
      ap_start = (c == 0);
    end
    ap_rst_n = 1'b0;
    #1;
    check_eq("abort_ret", ap_return, 0);
    check_eq("abort_done", ap_done, 0);
    check_eq("abort_bce", bli_ce0, 0);
    check_eq("abort_dadr", dlti_address0, 0);
    #2 ap_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge ap_clk); #5;
      check_eq($sformatf("abort_done_c%0d", c), ap_done, 0);
      check_eq($sformatf("abort_idle_c%0d", c), ap_idle, 1);
      check_eq($sformatf("abort_ret_c%0d", c), ap_return, 0);
    end
    $display("abort: ap_return=0x%08h ap_idle=%0b", ap_return, ap_idle);

    // ap_start held high: a result every 8 cycles, RAM reloaded during DONE
    random_mem();
    exp = ref_filter();
    @(posedge ap_clk); #1;
    ap_start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge ap_clk); #1; end
      #4;
      check_eq($sformatf("cont_done_c%0d", c), ap_done, (c % 8 == 7));
      if (c % 8 == 7) begin
        check_eq($sformatf("cont_ret_c%0d", c), ap_return, exp);
        $display("cont run %0d: ap_return=0x%08h expected=0x%08h", c / 8, ap_return, exp);
        random_mem();
        exp = ref_filter();
      end
    end
    ap_start = 1'b0;
    repeat (10) @(posedge ap_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
